vending_fsm_core: RTL and testbench

Sequential core of the vending machine: owns the transaction state register, latches the selected item and its price, accumulates inserted coins, runs the inactivity timeout and computes change. It sits directly upstream of the combinational output stage and drives that stage's `state`, `pop`, `money` and `item` inputs. It also produces the change amount, a refund flag and a coin-reject pulse for the coin mechanism.

---
 rtl/vending_fsm_core.sv | 182 ++++++++++++++++++
 tb/tb_vending_fsm_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vending_fsm_core : transaction FSM, price/item latch, coin credit, timeout,
//                    change computation and coin-reject pulse.  Rev 1.0
// ---------------------------------------------------------------------------
module vending_fsm_core #(
  parameter logic [4:0]  PRICE0  = 5'd10,
  parameter logic [4:0]  PRICE1  = 5'd15,
  parameter logic [4:0]  PRICE2  = 5'd20,
  parameter logic [4:0]  PRICE3  = 5'd25,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       item_valid,
  input  logic [1:0] item_sel,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       cancel,
  output logic [2:0] state,
  output logic [4:0] pop,
  output logic [4:0] money,
  output logic [1:0] item,
  output logic [4:0] change,
  output logic       refund,
  output logic       coin_reject
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_RECEIVE = 3'd2,
    S_COMPARE = 3'd3,
    S_PROCESS = 3'd4,
    S_RETURN  = 3'd5
  } state_e;

  localparam logic [7:0] C_IDLE_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [4:0] pop_q, pop_d;
  logic [4:0] money_q, money_d;
  logic [1:0] item_q, item_d;
  logic [4:0] change_q, change_d;
  logic       refund_q, refund_d;
  logic       coin_reject_q, coin_reject_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;

  logic       coin_present;
  logic [5:0] coin_sum;
  logic [4:0] coin_sat;
  logic [4:0] price_sel;

  always_comb begin
    coin_present = coin_valid && (coin_value != 5'd0);
    coin_sum     = {1'b0, money_q} + {1'b0, coin_value};
    coin_sat     = coin_sum[5] ? 5'd31 : coin_sum[4:0];
    case (item_sel)
      2'd0:    price_sel = PRICE0;
      2'd1:    price_sel = PRICE1;
      2'd2:    price_sel = PRICE2;
      default: price_sel = PRICE3;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pop_d         = pop_q;
    money_d       = money_q;
    item_d        = item_q;
    change_d      = change_q;
    refund_d      = refund_q;
    idle_cnt_d    = idle_cnt_q;
    coin_reject_d = coin_present && (state_q != S_RECEIVE);

    case (state_q)
      S_IDLE: begin
        money_d  = 5'd0;
        pop_d    = 5'd0;
        item_d   = 2'd0;
        change_d = 5'd0;
        refund_d = 1'b0;
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (item_valid) begin
          item_d  = item_sel;
          pop_d   = price_sel;
          state_d = S_COMPARE;
        end else if (cancel) begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (money_q >= pop_q) begin
          state_d = S_PROCESS;
        end else begin
          state_d    = S_RECEIVE;
          idle_cnt_d = 8'd0;
        end
      end
      S_RECEIVE: begin
        // A coin arriving with cancel is still credited before the refund.
        if (coin_present) begin
          money_d    = coin_sat;
          idle_cnt_d = 8'd0;
          if (cancel) begin
            change_d = coin_sat;
            pop_d    = 5'd0;
            refund_d = 1'b1;
            state_d  = S_RETURN;
          end else begin
            state_d = S_COMPARE;
          end
        end else if (cancel || (idle_cnt_q == C_IDLE_LAST)) begin
          change_d = money_q;
          pop_d    = 5'd0;
          refund_d = 1'b1;
          state_d  = S_RETURN;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      S_PROCESS: begin
        change_d = money_q - pop_q;
        refund_d = 1'b0;
        state_d  = S_RETURN;
      end
      S_RETURN: begin
        money_d  = 5'd0;
        pop_d    = 5'd0;
        item_d   = 2'd0;
        change_d = 5'd0;
        refund_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d       = S_IDLE;
        money_d       = 5'd0;
        pop_d         = 5'd0;
        item_d        = 2'd0;
        change_d      = 5'd0;
        refund_d      = 1'b0;
        idle_cnt_d    = 8'd0;
        coin_reject_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pop_q         <= 5'd0;
      money_q       <= 5'd0;
      item_q        <= 2'd0;
      change_q      <= 5'd0;
      refund_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      idle_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pop_q         <= pop_d;
      money_q       <= money_d;
      item_q        <= item_d;
      change_q      <= change_d;
      refund_q      <= refund_d;
      coin_reject_q <= coin_reject_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign state       = state_q;
  assign pop         = pop_q;
  assign money       = money_q;
  assign item        = item_q;
  assign change      = change_q;
  assign refund      = refund_q;
  assign coin_reject = coin_reject_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vending_fsm_core : directed scoreboard bench for vending_fsm_core. Rev 1.0
// ---------------------------------------------------------------------------
module tb_vending_fsm_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       item_valid;
  logic [1:0] item_sel;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       cancel;
  logic [2:0] state;
  logic [4:0] pop;
  logic [4:0] money;
  logic [1:0] item;
  logic [4:0] change;
  logic       refund;
  logic       coin_reject;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [4:0] pop;
    logic [4:0] money;
    logic [1:0] item;
    logic [4:0] change;
    logic       refund;
    logic       coin_reject;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] IDL = 3'd0, SEL = 3'd1, RCV = 3'd2, CMP = 3'd3, PRC = 3'd4, RET = 3'd5;

  vending_fsm_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .item_valid (item_valid),
    .item_sel   (item_sel),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .cancel     (cancel),
    .state      (state),
    .pop        (pop),
    .money      (money),
    .item       (item),
    .change     (change),
    .refund     (refund),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic drv(input logic s, input logic iv, input logic [1:0] is,
                     input logic cv, input logic [4:0] val, input logic cn);
    start      = s;
    item_valid = iv;
    item_sel   = is;
    coin_valid = cv;
    coin_value = val;
    cancel     = cn;
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [2:0] st, input logic [4:0] p,
                      input logic [4:0] m, input logic [1:0] it, input logic [4:0] ch,
                      input logic rf, input logic cr);
    exp_t e;
    e.tag = tag; e.st = st; e.pop = p; e.money = m; e.item = it;
    e.change = ch; e.refund = rf; e.coin_reject = cr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "state",       {5'd0, state},       {5'd0, e.st});
    chk(e.tag, "pop",         {3'd0, pop},         {3'd0, e.pop});
    chk(e.tag, "money",       {3'd0, money},       {3'd0, e.money});
    chk(e.tag, "item",        {6'd0, item},        {6'd0, e.item});
    chk(e.tag, "change",      {3'd0, change},      {3'd0, e.change});
    chk(e.tag, "refund",      {7'd0, refund},      {7'd0, e.refund});
    chk(e.tag, "coin_reject", {7'd0, coin_reject}, {7'd0, e.coin_reject});
    drv(0, 0, 2'd0, 0, 5'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1, 1, 2'd3, 1, 5'd7, 1);
    #2;
    step("reset", IDL, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Exact pay: item 1 (15) with coins 10 then 5
    drv(1, 0, 0, 0, 0, 0); step("ex_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0, 0); step("ex_item",  CMP, 15, 0, 1, 0, 0, 0);
    step("ex_recv0", RCV, 15, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 10, 0); step("ex_coin10", CMP, 15, 10, 1, 0, 0, 0);
    step("ex_recv1", RCV, 15, 10, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0); step("ex_zero_coin", RCV, 15, 10, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 5, 0); step("ex_coin5", CMP, 15, 15, 1, 0, 0, 0);
    step("ex_proc", PRC, 15, 15, 1, 0, 0, 0);
    step("ex_ret",  RET, 15, 15, 1, 0, 0, 0);
    step("ex_idle", IDL, 0, 0, 0, 0, 0, 0);

    // Overpay: item 0 (10) with a single 25 coin
    drv(1, 0, 0, 0, 0, 0); step("ov_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0); step("ov_item",  CMP, 10, 0, 0, 0, 0, 0);
    step("ov_recv", RCV, 10, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 25, 0); step("ov_coin_n1", CMP, 10, 25, 0, 0, 0, 0);
    step("ov_n2", PRC, 10, 25, 0, 0, 0, 0);
    step("ov_n3", RET, 10, 25, 0, 15, 0, 0);
    step("ov_n4", IDL, 0, 0, 0, 0, 0, 0);

    // Cancel together with a coin: item 3 (25), coin 10, then cancel+coin 5
    drv(1, 0, 0, 0, 0, 0); step("cn_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 3, 0, 0, 1); step("cn_item_wins", CMP, 25, 0, 3, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1); step("cn_cmp_ignores", RCV, 25, 0, 3, 0, 0, 0);
    drv(0, 0, 0, 1, 10, 0); step("cn_coin10", CMP, 25, 10, 3, 0, 0, 0);
    step("cn_recv", RCV, 25, 10, 3, 0, 0, 0);
    drv(0, 0, 0, 1, 5, 1); step("cn_refund", RET, 0, 15, 3, 15, 1, 0);
    step("cn_idle", IDL, 0, 0, 0, 0, 0, 0);

    // Timeout: item 2 (20), no coins
    drv(1, 0, 0, 0, 0, 0); step("to_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 2, 0, 0, 0); step("to_item",  CMP, 20, 0, 2, 0, 0, 0);
    step("to_enter", RCV, 20, 0, 2, 0, 0, 0);
    for (int i = 1; i < 16; i++) step($sformatf("to_wait%0d", i), RCV, 20, 0, 2, 0, 0, 0);
    step("to_expire", RET, 0, 0, 2, 0, 1, 0);
    step("to_idle", IDL, 0, 0, 0, 0, 0, 0);

    // Saturation: item 3 (25), coins 20 and 20
    drv(1, 0, 0, 0, 0, 0); step("sat_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 3, 0, 0, 0); step("sat_item",  CMP, 25, 0, 3, 0, 0, 0);
    step("sat_recv0", RCV, 25, 0, 3, 0, 0, 0);
    drv(0, 0, 0, 1, 20, 0); step("sat_coin1", CMP, 25, 20, 3, 0, 0, 0);
    step("sat_recv1", RCV, 25, 20, 3, 0, 0, 0);
    drv(0, 0, 0, 1, 20, 0); step("sat_coin2", CMP, 25, 31, 3, 0, 0, 0);
    step("sat_proc", PRC, 25, 31, 3, 0, 0, 0);
    step("sat_ret",  RET, 25, 31, 3, 6, 0, 0);
    step("sat_idle", IDL, 0, 0, 0, 0, 0, 0);

    // Coin rejects outside RECEIVE_MONEY, back-to-back, and cancel in SELECT
    drv(0, 0, 0, 1, 5, 0); step("rej_idle", IDL, 0, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 1, 5, 0); step("rej_b2b", SEL, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 5, 0); step("rej_sel", SEL, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1); step("rej_end_cancel", IDL, 0, 0, 0, 0, 0, 0);

    // Reset mid-transaction with money=10 in RECEIVE_MONEY
    drv(1, 0, 0, 0, 0, 0); step("rs_start", SEL, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0, 0); step("rs_item",  CMP, 15, 0, 1, 0, 0, 0);
    step("rs_recv", RCV, 15, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 10, 0); step("rs_coin", CMP, 15, 10, 1, 0, 0, 0);
    step("rs_recv10", RCV, 15, 10, 1, 0, 0, 0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step("rs_async_glitch", RCV, 15, 10, 1, 0, 0, 0);
    rst_n = 1'b0;
    step("rs_sync", IDL, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("rs_after", IDL, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
